fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Pipeline forwarding and load-use hazard controller for the 5-stage MIPS core.
- Tracks the destination registers of in-flight instructions in a shadow pipeline covering EX, MEM, WB and one post-WB slot.
- Produces the registered 2-bit select codes for the two ALU-operand 4:1 muxes in EX.
- Produces the combinational stall request that freezes PC and IF/ID.

Parameters:
REG_ADDR_W, 5, register-address width
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous, active-high reset
id_valid_i  input  1  ID stage holds a real instruction
id_rs_i  input  REG_ADDR_W  ID source register A
id_rt_i  input  REG_ADDR_W  ID source register B
id_rd_i  input  REG_ADDR_W  ID destination register, already resolved (rd/rt/31)
id_regwrite_i  input  1  ID instruction writes the register file
id_memread_i  input  1  ID instruction is a load
flush_i  input  1  kill ID instruction (taken branch/jump)
stall_o  output  1  freeze PC and IF/ID this cycle
ex_fwd_a_sel_o  output  2  select for operand-A mux in EX
ex_fwd_b_sel_o  output  2  select for operand-B mux in EX
stall_cnt_o  output  CNT_W  number of stall cycles issued, saturating

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Select encoding:
  - 0 = register-file read data
  - 1 = EX/MEM ALU result
  - 2 = MEM/WB write-back data
  - 3 = WB bypass latch, the value retired one cycle earlier
- Shadow pipeline:
  - Four records: EX, MEM, WB, POST.
  - Each record holds {valid, regwrite, memread, rd}.
  - All records advance every clock: EX<-ID entry, MEM<-EX, WB<-MEM, POST<-WB.
- ID entry:
  - It is a bubble (valid=0) when stall_o=1, flush_i=1 or id_valid_i=0.
  - Otherwise it is the ID fields.
- A record "produces r" when valid & regwrite & rd==r & r!=0.
- Select computation, at the edge where ID enters EX:
  - Selects are computed for rs (A) and rt (B) against the pre-edge EX, MEM and WB records.
  - Pre-edge EX produces -> 1. Else MEM produces -> 2. Else WB produces -> 3. Else 0.
  - The youngest producer always wins.
  - The computed selects are registered into ex_fwd_*_sel_o.
  - When the entry is a bubble, both selects register 0.
- Load-use hazard:
  - hazard = EX record valid & memread & regwrite & rd!=0 & (rd==id_rs_i | rd==id_rt_i).
  - stall_o = hazard & id_valid_i & ~flush_i. It is combinational and held for exactly one cycle, because the bubble clears the EX record.
  - After the stall, the load sits in MEM while the consumer is still in ID, so the consumer enters EX with sel=2.
- A load never yields sel=1; the stall guarantees this.
- id_rt_i is compared even for I-type instructions. Spurious sel on operand B is harmless because the immediate mux sits downstream. Spurious stalls are accepted.
- stall_cnt_o increments by 1 on every cycle with stall_o=1. It saturates at all-ones.
- flush_i together with a hazard: flush wins. stall_o=0, the entry becomes a bubble, no count.
- Reset (any cycle, including mid-stall):
  - All records become invalid.
  - ex_fwd_a_sel_o=0, ex_fwd_b_sel_o=0, stall_cnt_o=0.
  - stall_o=0 on the following cycle.
- Latency: sel outputs are valid on the same cycle the consumer instruction occupies EX. There are no internal wait states.

Decomposition:
- Shared package:
  - REG_ADDR_W default.
  - Select constants FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2, FWD_WBBYP=2'd3.
  - Stage-record typedef {valid, regwrite, memread, rd}.
- Sub-module fwd_sel_encoder:
  - Combinational priority encoder.
  - Inputs: source register plus the EX/MEM/WB records. Output: 2-bit select.
  - Instantiated twice, once for rs and once for rt.

Test Plan:
1. ALU-to-ALU forwarding distances:
   - Cycle 0: add $3 in ID (regwrite, rd=3).
   - Cycle 1: sub with rs=3 -> when sub is in EX, ex_fwd_a_sel_o=1.
   - Producer-consumer distance 2 -> 2; distance 3 -> 3; distance 4 -> 0.
2. Load-use:
   - lw $5 followed immediately by add with rt=5 -> stall_o=1 for exactly one cycle, EX receives a bubble with sels 0.
   - Then the add reaches EX with ex_fwd_b_sel_o=2 and stall_cnt_o=1.
   - lw $5 followed by add with rt=5 at distance 2 -> no stall, sel_b=2.
3. Register zero:
   - Producer with rd=0 and regwrite=1, consumer with rs=0, rt=0 -> both sels 0.
   - lw to $0 followed by a $0 consumer -> stall_o=0.
4. Priority:
   - Writers to $7 at distances 1 and 2, consumer with rs=7, rt=7 -> both sels 1.
   - Same with writers at distances 2 and 3 -> both sels 2.
5. Flush:
   - Load-use hazard with flush_i=1 in the same cycle -> stall_o=0, stall_cnt_o unchanged, EX bubble with sels 0.
   - Next instruction with no dependency -> sels 0.
6. Reset and saturation:
   - Assert rst_i during a stall cycle -> next cycle stall_o=0, sels 0, stall_cnt_o=0.
   - A dependent instruction issued right after reset is not forwarded (sel 0).
   - With CNT_W=2, five load-use stalls -> stall_cnt_o=3.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and select codes for the forwarding / load-use hazard unit.
// Imported by the select encoder and the top-level controller.
package fwd_hazard_unit_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;
    localparam logic [1:0] FWD_WBBYP = 2'd3;

    typedef struct packed {
        logic                      valid;
        logic                      regwrite;
        logic                      memread;
        logic [DEF_REG_ADDR_W-1:0] rd;
    } stage_rec_t;

    localparam stage_rec_t REC_BUBBLE = '0;

    // A record produces r when it will write r and r is not $0.
    function automatic logic rec_produces(
        input stage_rec_t                rec,
        input logic [DEF_REG_ADDR_W-1:0] r
    );
        return rec.valid && rec.regwrite &&
               (rec.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_sel_encoder.sv
// Priority encoder picking the youngest in-flight producer of one source
// register; the result drives one EX operand mux select.
module fwd_sel_encoder
    import fwd_hazard_unit_pkg::*;
(
    input  logic [DEF_REG_ADDR_W-1:0] src_i,
    input  stage_rec_t                ex_i,
    input  stage_rec_t                mem_i,
    input  stage_rec_t                wb_i,
    output logic [1:0]                sel_o
);

    // Load status does not affect the select; the stall keeps loads out
    // of the EX/MEM slot whenever a consumer would need them there.
    logic unused_memread;
    assign unused_memread = ex_i.memread ^ mem_i.memread ^ wb_i.memread;

    // Youngest producer wins: EX, then MEM, then WB, else register file.
    always_comb begin
        sel_o = FWD_RF;
        if (rec_produces(ex_i, src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (rec_produces(mem_i, src_i)) begin
            sel_o = FWD_MEMWB;
        end else if (rec_produces(wb_i, src_i)) begin
            sel_o = FWD_WBBYP;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall controller for the 5-stage core.
// Keeps a shadow pipeline of destination registers (EX, MEM, WB, POST).
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic [1:0]            ex_fwd_a_sel_o,
    output logic [1:0]            ex_fwd_b_sel_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    stage_rec_t ex_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;
    stage_rec_t post_q;
    stage_rec_t ex_d;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] sel_a_q;
    logic [1:0] sel_b_q;
    logic [1:0] sel_a_d;
    logic [1:0] sel_b_d;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic hazard;
    logic id_live;

    // POST mirrors the datapath WB bypass latch; no select logic reads it.
    logic unused_post;
    assign unused_post = ^post_q;

    // Load in EX whose result the instruction in ID needs right away.
    always_comb begin
        hazard = ex_q.valid && ex_q.memread && ex_q.regwrite &&
                 (ex_q.rd != '0) &&
                 ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i));
    end

    assign stall_o = hazard && id_valid_i && !flush_i;

    fwd_sel_encoder u_enc_a (
        .src_i (id_rs_i),
        .ex_i  (ex_q),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (sel_a)
    );

    fwd_sel_encoder u_enc_b (
        .src_i (id_rt_i),
        .ex_i  (ex_q),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (sel_b)
    );

    // Build the ID entry and next selects; stalls and flushes inject bubbles.
    always_comb begin
        id_live = id_valid_i && !flush_i && !stall_o;
        ex_d    = REC_BUBBLE;
        sel_a_d = FWD_RF;
        sel_b_d = FWD_RF;
        if (id_live) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
            ex_d.rd       = id_rd_i;
            sel_a_d       = sel_a;
            sel_b_d       = sel_b;
        end
    end

    // Saturating count of issued stall cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Shadow pipeline, registered selects and stall counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q    <= REC_BUBBLE;
            mem_q   <= REC_BUBBLE;
            wb_q    <= REC_BUBBLE;
            post_q  <= REC_BUBBLE;
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            post_q  <= wb_q;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_fwd_a_sel_o = sel_a_q;
    assign ex_fwd_b_sel_o = sel_b_q;
    assign stall_cnt_o    = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit (counter width 2 so that
// saturation is reachable with a handful of load-use stalls).
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          id_valid_i = 1'b0;
    logic [AW-1:0] id_rs_i = '0;
    logic [AW-1:0] id_rt_i = '0;
    logic [AW-1:0] id_rd_i = '0;
    logic          id_regwrite_i = 1'b0;
    logic          id_memread_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          stall_o;
    logic [1:0]    ex_fwd_a_sel_o;
    logic [1:0]    ex_fwd_b_sel_o;
    logic [CW-1:0] stall_cnt_o;

    fwd_hazard_unit #(
        .REG_ADDR_W (AW),
        .CNT_W      (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_rd_i        (id_rd_i),
        .id_regwrite_i  (id_regwrite_i),
        .id_memread_i   (id_memread_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .ex_fwd_a_sel_o (ex_fwd_a_sel_o),
        .ex_fwd_b_sel_o (ex_fwd_b_sel_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int st;
        int a;
        int b;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   row_n  = 0;

    function automatic void chk(string nm, int row, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d",
                     nm, row, act, req);
        end
    endfunction

    // Drive one ID cycle and queue what the outputs must show this cycle:
    // stall for this ID, selects of the previous ID entry, count so far.
    task automatic step(
        input logic rst, input logic v,
        input int rs, input int rt, input int rd,
        input logic rw, input logic mr, input logic fl,
        input int est, input int ea, input int eb, input int ec
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_i         = rst;
        id_valid_i    = v;
        id_rs_i       = AW'(rs);
        id_rt_i       = AW'(rt);
        id_rd_i       = AW'(rd);
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        row_n++;
        e.row = row_n;
        e.st  = est;
        e.a   = ea;
        e.b   = eb;
        e.cnt = ec;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("stall", e.row, int'(stall_o), e.st);
                chk("sel_a", e.row, int'(ex_fwd_a_sel_o), e.a);
                chk("sel_b", e.row, int'(ex_fwd_b_sel_o), e.b);
                chk("cnt", e.row, int'(stall_cnt_o), e.cnt);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        // distance 1 / 2 / 3 / 4 ALU forwarding
        step(0,1,0,0,3,1,0,0, 0,0,0,0);
        step(0,1,3,0,10,0,0,0, 0,0,0,0);
        step(0,0,0,0,0,0,0,0, 0,1,0,0);
        step(0,1,0,0,4,1,0,0, 0,0,0,0);
        step(0,0,0,0,0,0,0,0, 0,0,0,0);
        step(0,1,4,0,10,0,0,0, 0,0,0,0);
        step(0,1,0,0,6,1,0,0, 0,2,0,0);
        step(0,0,0,0,0,0,0,0, 0,0,0,0);
        step(0,0,0,0,0,0,0,0, 0,0,0,0);
        step(0,1,6,0,10,0,0,0, 0,0,0,0);
        step(0,1,0,0,8,1,0,0, 0,3,0,0);
        step(0,0,0,0,0,0,0,0, 0,0,0,0);
        step(0,0,0,0,0,0,0,0, 0,0,0,0);
        step(0,0,0,0,0,0,0,0, 0,0,0,0);
        step(0,1,8,8,10,0,0,0, 0,0,0,0);
        step(0,0,0,0,0,0,0,0, 0,0,0,0);
        // load-use at distance 1 (one stall) and distance 2 (none)
        step(0,1,0,0,5,1,1,0, 0,0,0,0);
        step(0,1,0,5,10,0,0,0, 1,0,0,0);
        step(0,1,0,5,10,0,0,0, 0,0,0,1);
        step(0,0,0,0,0,0,0,0, 0,0,2,1);
        step(0,1,0,0,9,1,1,0, 0,0,0,1);
        step(0,0,0,0,0,0,0,0, 0,0,0,1);
        step(0,1,0,9,10,0,0,0, 0,0,0,1);
        step(0,0,0,0,0,0,0,0, 0,0,2,1);
        // register zero never forwards or stalls
        step(0,1,0,0,0,1,0,0, 0,0,0,1);
        step(0,1,0,0,10,0,0,0, 0,0,0,1);
        step(0,1,0,0,0,1,1,0, 0,0,0,1);
        step(0,1,0,0,10,0,0,0, 0,0,0,1);
        step(0,0,0,0,0,0,0,0, 0,0,0,1);
        // priority: youngest producer wins
        step(0,1,0,0,7,1,0,0, 0,0,0,1);
        step(0,1,0,0,7,1,0,0, 0,0,0,1);
        step(0,1,7,7,10,0,0,0, 0,0,0,1);
        step(0,0,0,0,0,0,0,0, 0,1,1,1);
        step(0,1,0,0,7,1,0,0, 0,0,0,1);
        step(0,1,0,0,7,1,0,0, 0,0,0,1);
        step(0,0,0,0,0,0,0,0, 0,0,0,1);
        step(0,1,7,7,10,0,0,0, 0,0,0,1);
        step(0,0,0,0,0,0,0,0, 0,2,2,1);
        // flush beats a load-use hazard
        step(0,1,0,0,11,1,1,0, 0,0,0,1);
        step(0,1,11,0,10,0,0,1, 0,0,0,1);
        step(0,1,12,13,10,0,0,0, 0,0,0,1);
        step(0,0,0,0,0,0,0,0, 0,0,0,1);
        // reset during a stall cycle
        step(0,1,0,0,5,1,1,0, 0,0,0,1);
        step(1,1,0,5,10,0,0,0, 1,0,0,1);
        step(0,1,0,5,10,0,0,0, 0,0,0,0);
        step(0,0,0,0,0,0,0,0, 0,0,0,0);
        // five load-use stalls saturate a 2-bit counter at 3
        for (int k = 0; k < 5; k++) begin
            step(0,1,0,0,5,1,1,0, 0,0,(k == 0) ? 0 : 2,
                 (k > 3) ? 3 : k);
            step(0,1,0,5,10,0,0,0, 1,0,0, (k > 3) ? 3 : k);
            step(0,1,0,5,10,0,0,0, 0,0,0, (k > 2) ? 3 : k + 1);
        end
        step(0,0,0,0,0,0,0,0, 0,0,2,3);
        for (int i = 0; i < 8 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
